pong_paddle_score: RTL and testbench
====================================

// Module: pong_paddle_score
// PURPOSE
//  Game-control counterpart of the Pong ball renderer. Drives pos_yBarra1/2 and enablePong into it.
//  Consumes its pointPlayer1/2 outputs. Moves both paddles from player buttons once per video frame.
//  Keeps the scores and runs the IDLE/PLAY/SERVE/OVER game state machine.
// PARAMETERS
//  PADDLE_H      90   paddle height in lines; bottom clamp = Y_MAX-PADDLE_H
//  PADDLE_STEP   4    lines moved per frame tick while a button is held
//  Y_MAX         480  visible lines
//  WIN_SCORE     9    score that ends the game (must be <= 15)
//  SERVE_FRAMES  60   frame ticks enablePong stays low after a point (auto-serve only)
// PORTS
//  clk_in        in   1  system clock (only clock)
//  i_rst         in   1  synchronous, active-high reset
//  o_x           in   10 current pixel x from VGA timing
//  o_y           in   9  current pixel y from VGA timing
//  btn_up1/btn_dn1 in 1  player 1 up/down, asynchronous, active high
//  btn_up2/btn_dn2 in 1  player 2 up/down, asynchronous, active high
//  btn_start     in   1  start/serve/restart, asynchronous, active high
//  pointPlayer1  in   1  player 1 scored (level from ball block)
//  pointPlayer2  in   1  player 2 scored (level from ball block)
//  pos_yBarra1   out  9  paddle 1 top y
//  pos_yBarra2   out  9  paddle 2 top y
//  enablePong    out  1  ball motion/draw enable
//  score1        out  4  player 1 score
//  score2        out  4  player 2 score
//  winner        out  2  00 none, 01 player 1, 10 player 2, 11 draw
// BEHAVIOUR
//  Reset (sync, i_rst=1 at posedge):
//   - pos_yBarra1 = pos_yBarra2 = (Y_MAX-PADDLE_H)/2 = 195.
//   - score1 = score2 = 0, winner = 0, enablePong = 0, state = IDLE.
//   - Synchroniser, edge-detect and serve-counter flops all cleared.
//   - Reset mid-game aborts immediately with no partial update.
//  Inputs:
//   - All five buttons pass through 2-FF synchronisers.
//   - btn_start acts on its synchronised 0->1 edge only.
//   - frame_tick is a registered 1-cycle pulse, raised the cycle after o_x==639 && o_y==479.
//  Paddles:
//   - Update only on frame_tick, and only in PLAY or SERVE.
//   - up: y = max(y-PADDLE_STEP, 0); down: y = min(y+PADDLE_STEP, Y_MAX-PADDLE_H).
//   - Both buttons held: no move. Clamp is computed with 10-bit arithmetic, so no wrap below 0.
//  Points:
//   - pointPlayerN is a level. A point counts on its registered 0->1 transition only, 1 per edge.
//   - Edges are ignored outside PLAY.
//   - Simultaneous edges on both inputs: both scores increment in the same cycle.
//   - Scores saturate at WIN_SCORE.
//  FSM (2-bit state, enablePong = (state==PLAY)):
//   - IDLE  -> PLAY on start edge.
//   - PLAY  -> OVER on a point edge whose new score == WIN_SCORE. winner set in the same cycle;
//              11 if both players reach WIN_SCORE in the same cycle.
//   - PLAY  -> SERVE on any other point edge. Serve counter loads 0.
//   - SERVE -> PLAY per CONFIGURATION.
//   - OVER  -> IDLE on start edge. Scores and winner cleared, paddles recentred in the same cycle.
//  Latency: point edge to score/state change is 2 clk_in after the pointPlayer rise (1 edge-register stage + 1 update).
// CONFIGURATION
//  PONG_AUTO_SERVE_EN defined:
//   - SERVE counts frame ticks and moves to PLAY on the tick where count reaches SERVE_FRAMES-1.
//   - A start edge in SERVE also moves to PLAY immediately.
//  PONG_AUTO_SERVE_EN undefined:
//   - SERVE leaves only on a start edge. The counter is not built.
// TESTING
//  - Reset, then 3 frames with no buttons -> paddles 195/195, scores 0, enablePong 0, state IDLE.
//  - Start edge, then btn_up1 held 60 frames -> pos_yBarra1 decreases by 4/frame to 0 and holds.
//    Same with btn_dn2 -> pos_yBarra2 stops at 390.
//  - In PLAY, pointPlayer1 0->1 held high 10 cycles -> score1=1 exactly once, enablePong=0 two cycles after the rise.
//  - Auto-serve build, SERVE_FRAMES=60 -> enablePong returns to 1 after 60 frame ticks.
//    Non-auto build -> stays 0 until start edge.
//  - score1=8, score2=8, both pointPlayer inputs rise in the same cycle -> scores 9/9, winner=11, state OVER.
//  - i_rst asserted in SERVE mid-count -> next cycle all outputs at reset values.
//    Start edge then needed to re-enter PLAY.

Source files
------------

// File: rtl/pong_paddle_score_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pong_paddle_score_if                                         |
// | Description : Signal bundle between the game-control block and its         |
// |               surroundings (VGA timing, player buttons, ball renderer).     |
// |   master : drives pixel position, buttons and point levels; reads paddles, |
// |            ball enable, scores and winner.                                 |
// |   slave  : the pong_paddle_score block itself.                              |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface pong_paddle_score_if;
  logic [9:0] o_x;           // current pixel x from VGA timing
  logic [8:0] o_y;           // current pixel y from VGA timing
  logic       btn_up1;       // player 1 up   (asynchronous)
  logic       btn_dn1;       // player 1 down (asynchronous)
  logic       btn_up2;       // player 2 up   (asynchronous)
  logic       btn_dn2;       // player 2 down (asynchronous)
  logic       btn_start;     // start / serve / restart (asynchronous)
  logic       pointPlayer1;  // player 1 scored (level)
  logic       pointPlayer2;  // player 2 scored (level)
  logic [8:0] pos_yBarra1;   // paddle 1 top y
  logic [8:0] pos_yBarra2;   // paddle 2 top y
  logic       enablePong;    // ball motion/draw enable
  logic [3:0] score1;        // player 1 score
  logic [3:0] score2;        // player 2 score
  logic [1:0] winner;        // 00 none, 01 p1, 10 p2, 11 draw

  modport master (
    output o_x, o_y, btn_up1, btn_dn1, btn_up2, btn_dn2, btn_start,
           pointPlayer1, pointPlayer2,
    input  pos_yBarra1, pos_yBarra2, enablePong, score1, score2, winner
  );

  modport slave (
    input  o_x, o_y, btn_up1, btn_dn1, btn_up2, btn_dn2, btn_start,
           pointPlayer1, pointPlayer2,
    output pos_yBarra1, pos_yBarra2, enablePong, score1, score2, winner
  );
endinterface
`default_nettype wire

// File: rtl/pong_paddle_score.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pong_paddle_score                                            |
// | Description : Pong game control. Moves both paddles from player buttons     |
// |               once per video frame, keeps the scores and runs the           |
// |               IDLE/PLAY/SERVE/OVER game state machine.                      |
// | Ports       : clk_in  system clock                                          |
// |               i_rst   synchronous active-high reset                         |
// |               bus     pong_paddle_score_if.slave (pixel position, buttons,  |
// |                       point levels in; paddles, enable, scores, winner out) |
// | Option      : PONG_AUTO_SERVE_EN - when defined, SERVE returns to PLAY by    |
// |               itself after SERVE_FRAMES frame ticks; otherwise only a       |
// |               start edge leaves SERVE and the serve counter is not built.   |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module pong_paddle_score #(
  parameter int PADDLE_H     = 90,
  parameter int PADDLE_STEP  = 4,
  parameter int Y_MAX        = 480,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  wire logic         clk_in,
  input  wire logic         i_rst,
  pong_paddle_score_if.slave bus
);

  localparam logic [9:0] C_Y_BOT = 10'(Y_MAX - PADDLE_H);
  localparam logic [8:0] C_Y_CTR = 9'((Y_MAX - PADDLE_H) / 2);
  localparam logic [9:0] C_STEP  = 10'(PADDLE_STEP);
  localparam logic [3:0] C_WIN   = 4'(WIN_SCORE);

  // Scores are 4 bits wide, and a serve delay of zero frames is meaningless.
  generate
    if (WIN_SCORE < 1 || WIN_SCORE > 15 || SERVE_FRAMES < 1) begin : g_param_check
      $error("pong_paddle_score: WIN_SCORE must be 1..15 and SERVE_FRAMES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SERVE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Button bit order: 0 up1, 1 dn1, 2 up2, 3 dn2, 4 start
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       start_prev_q, start_prev_d;
  logic [1:0] pt_q, pt_d, pt_prev_q, pt_prev_d;
  logic       frame_tick_q, frame_tick_d;
  state_t     state_q, state_d;
  logic [8:0] y1_q, y1_d, y2_q, y2_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
`ifdef PONG_AUTO_SERVE_EN
  localparam int C_CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SERVE_FRAMES - 1);
  logic [C_CNT_W-1:0] serve_cnt_q, serve_cnt_d;
`endif

  logic       w_start_edge;
  logic [1:0] w_pt_edge;
  logic [3:0] w_sc1_inc, w_sc2_inc;
  logic       w_win1, w_win2;

  assign w_start_edge = sync2_q[4] & ~start_prev_q;
  assign w_pt_edge    = pt_q & ~pt_prev_q;
  assign w_sc1_inc    = (score1_q < C_WIN) ? score1_q + 4'd1 : score1_q;
  assign w_sc2_inc    = (score2_q < C_WIN) ? score2_q + 4'd1 : score2_q;
  assign w_win1       = w_pt_edge[0] && (w_sc1_inc == C_WIN);
  assign w_win2       = w_pt_edge[1] && (w_sc2_inc == C_WIN);

  // Clamped paddle move. Widening to 10 bits makes an underflow show up in
  // bit 9 instead of wrapping to a large positive line number.
  function automatic logic [8:0] move(input logic [8:0] y, input logic up,
                                      input logic dn);
    logic [9:0] y_up;
    logic [9:0] y_dn;
    y_up = {1'b0, y} - C_STEP;
    y_dn = {1'b0, y} + C_STEP;
    move = y;
    if (up && !dn) begin
      move = y_up[9] ? 9'd0 : y_up[8:0];
    end else if (dn && !up) begin
      move = (y_dn > C_Y_BOT) ? C_Y_BOT[8:0] : y_dn[8:0];
    end
  endfunction

  always_comb begin
    sync1_d      = {bus.btn_start, bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1};
    sync2_d      = sync1_q;
    start_prev_d = sync2_q[4];
    pt_d         = {bus.pointPlayer2, bus.pointPlayer1};
    pt_prev_d    = pt_q;
    frame_tick_d = (bus.o_x == 10'd639) && (bus.o_y == 9'd479);
    state_d      = state_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
`ifdef PONG_AUTO_SERVE_EN
    serve_cnt_d  = serve_cnt_q;
`endif

    if (frame_tick_q && (state_q == ST_PLAY || state_q == ST_SERVE)) begin
      y1_d = move(y1_q, sync2_q[0], sync2_q[1]);
      y2_d = move(y2_q, sync2_q[2], sync2_q[3]);
    end

    case (state_q)
      ST_IDLE: begin
        if (w_start_edge) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_pt_edge != 2'b00) begin
          if (w_pt_edge[0]) score1_d = w_sc1_inc;
          if (w_pt_edge[1]) score2_d = w_sc2_inc;
          if (w_win1 || w_win2) begin
            state_d  = ST_OVER;
            winner_d = {w_win2, w_win1};
          end else begin
            state_d = ST_SERVE;
`ifdef PONG_AUTO_SERVE_EN
            serve_cnt_d = '0;
`endif
          end
        end
      end
      ST_SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
        if (w_start_edge) begin
          state_d = ST_PLAY;
        end else if (frame_tick_q) begin
          if (serve_cnt_q == C_CNT_LAST) state_d = ST_PLAY;
          else serve_cnt_d = serve_cnt_q + 1'b1;
        end
`else
        if (w_start_edge) state_d = ST_PLAY;
`endif
      end
      ST_OVER: begin
        if (w_start_edge) begin
          state_d  = ST_IDLE;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          y1_d     = C_Y_CTR;
          y2_d     = C_Y_CTR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      start_prev_q <= 1'b0;
      pt_q         <= 2'b00;
      pt_prev_q    <= 2'b00;
      frame_tick_q <= 1'b0;
      state_q      <= ST_IDLE;
      y1_q         <= C_Y_CTR;
      y2_q         <= C_Y_CTR;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
`ifdef PONG_AUTO_SERVE_EN
      serve_cnt_q  <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      start_prev_q <= start_prev_d;
      pt_q         <= pt_d;
      pt_prev_q    <= pt_prev_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
`ifdef PONG_AUTO_SERVE_EN
      serve_cnt_q  <= serve_cnt_d;
`endif
    end
  end

  assign bus.pos_yBarra1 = y1_q;
  assign bus.pos_yBarra2 = y2_q;
  assign bus.enablePong  = (state_q == ST_PLAY);
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_paddle_score.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pong_paddle_score                                         |
// | Description : Self-checking bench for pong_paddle_score. A behavioural game |
// |               model pushes expected outputs into a scoreboard queue as      |
// |               stimulus is applied; the queue is drained against the DUT.    |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_pong_paddle_score;

  localparam int P_H   = 90;
  localparam int STEP  = 4;
  localparam int YMAX  = 480;
  localparam int WIN   = 9;
  localparam int SF    = 60;
  localparam int Y_CTR = (YMAX - P_H) / 2;
  localparam int Y_BOT = YMAX - P_H;

  localparam int S_IDLE = 0, S_PLAY = 1, S_SERVE = 2, S_OVER = 3;

  logic clk_in = 1'b0;
  logic i_rst;
  always #5 clk_in = ~clk_in;

  pong_paddle_score_if bus();

  pong_paddle_score #(
    .PADDLE_H(P_H), .PADDLE_STEP(STEP), .Y_MAX(YMAX),
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF)
  ) dut (
    .clk_in (clk_in),
    .i_rst  (i_rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef enum int {O_Y1, O_Y2, O_EN, O_S1, O_S2, O_WIN} obs_e;
  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] observe(input obs_e s);
    case (s)
      O_Y1:    observe = 32'(bus.pos_yBarra1);
      O_Y2:    observe = 32'(bus.pos_yBarra2);
      O_EN:    observe = 32'(bus.enablePong);
      O_S1:    observe = 32'(bus.score1);
      O_S2:    observe = 32'(bus.score2);
      default: observe = 32'(bus.winner);
    endcase
  endfunction

  task automatic push(input string tag, input obs_e sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  // ---------------- game model ----------------
  int m_y1, m_y2, m_s1, m_s2, m_win, m_state, m_cnt;

  task automatic m_reset();
    m_y1 = Y_CTR; m_y2 = Y_CTR; m_s1 = 0; m_s2 = 0;
    m_win = 0; m_state = S_IDLE; m_cnt = 0;
  endtask

  function automatic int m_move(input int y, input logic up, input logic dn);
    if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
    if (dn && !up) return (y + STEP > Y_BOT) ? Y_BOT : y + STEP;
    return y;
  endfunction

  task automatic push_all(input string tag);
    push({tag, ".y1"},  O_Y1,  m_y1);
    push({tag, ".y2"},  O_Y2,  m_y2);
    push({tag, ".en"},  O_EN,  (m_state == S_PLAY) ? 1 : 0);
    push({tag, ".s1"},  O_S1,  m_s1);
    push({tag, ".s2"},  O_S2,  m_s2);
    push({tag, ".win"}, O_WIN, m_win);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_frame();
    cyc(2);
    bus.o_x = 10'd639;
    bus.o_y = 9'd479;
    cyc(1);
    bus.o_x = 10'd0;
    bus.o_y = 9'd0;
    cyc(3);
    if (m_state == S_PLAY || m_state == S_SERVE) begin
      m_y1 = m_move(m_y1, bus.btn_up1, bus.btn_dn1);
      m_y2 = m_move(m_y2, bus.btn_up2, bus.btn_dn2);
    end
`ifdef PONG_AUTO_SERVE_EN
    if (m_state == S_SERVE) begin
      if (m_cnt == SF - 1) m_state = S_PLAY;
      else m_cnt++;
    end
`endif
  endtask

  task automatic do_start();
    bus.btn_start = 1'b1;
    cyc(4);
    bus.btn_start = 1'b0;
    cyc(4);
    case (m_state)
      S_IDLE, S_SERVE: m_state = S_PLAY;
      S_OVER: begin
        m_state = S_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
        m_y1 = Y_CTR; m_y2 = Y_CTR;
      end
      default: ;
    endcase
  endtask

  // Raise the requested point levels, check the 2-cycle latency, hold, drop.
  task automatic do_point(input string tag, input logic p1, input logic p2, input int hold);
    int n1, n2;
    bit w1, w2;
    bus.pointPlayer1 = p1;
    bus.pointPlayer2 = p2;
    cyc(1);
    push({tag, ".lat1"}, O_EN, (m_state == S_PLAY) ? 1 : 0);
    drain();
    cyc(1);
    if (m_state == S_PLAY) begin
      n1 = p1 ? ((m_s1 < WIN) ? m_s1 + 1 : m_s1) : m_s1;
      n2 = p2 ? ((m_s2 < WIN) ? m_s2 + 1 : m_s2) : m_s2;
      w1 = p1 && (n1 == WIN);
      w2 = p2 && (n2 == WIN);
      m_s1 = n1;
      m_s2 = n2;
      if (w1 || w2) begin
        m_state = S_OVER;
        m_win = (w2 ? 2 : 0) + (w1 ? 1 : 0);
      end else if (p1 || p2) begin
        m_state = S_SERVE;
        m_cnt = 0;
      end
    end
    push_all({tag, ".lat2"});
    drain();
    cyc(hold - 2);
    bus.pointPlayer1 = 1'b0;
    bus.pointPlayer2 = 1'b0;
    cyc(3);
    push_all({tag, ".after"});
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    bus.o_x = 10'd0; bus.o_y = 9'd0;
    bus.btn_up1 = 1'b0; bus.btn_dn1 = 1'b0;
    bus.btn_up2 = 1'b0; bus.btn_dn2 = 1'b0;
    bus.btn_start = 1'b0;
    bus.pointPlayer1 = 1'b0; bus.pointPlayer2 = 1'b0;
    cyc(3);
    i_rst = 1'b0;
    m_reset();
    push_all("rst");
    drain();

    // IDLE: frames do not move paddles, even with a button held
    repeat (3) do_frame();
    push_all("idle3f");
    drain();
    bus.btn_up1 = 1'b1;
    do_frame();
    bus.btn_up1 = 1'b0;
    push_all("idle_btn");
    drain();

    do_start();
    push_all("start");
    drain();

    // Paddle 1 up to the top clamp, paddle 2 down to the bottom clamp
    bus.btn_up1 = 1'b1;
    bus.btn_dn2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      do_frame();
      push($sformatf("up1_f%0d", i), O_Y1, m_y1);
      push($sformatf("dn2_f%0d", i), O_Y2, m_y2);
      drain();
    end
    bus.btn_dn2 = 1'b0;
    bus.btn_dn1 = 1'b1;
    do_frame();
    push_all("both_held");
    drain();
    bus.btn_up1 = 1'b0;
    bus.btn_dn1 = 1'b0;

    // Point for player 1 held 10 cycles counts once
    do_point("pt1", 1'b1, 1'b0, 10);
    // Point edges are ignored in SERVE
    do_point("pt2_serve", 1'b0, 1'b1, 4);

    // Paddles still move in SERVE
    bus.btn_dn1 = 1'b1;
    do_frame();
    bus.btn_dn1 = 1'b0;
    push_all("serve_move");
    drain();

`ifdef PONG_AUTO_SERVE_EN
    for (int i = 1; i < SF - 1; i++) do_frame();
    push("serve_wait", O_EN, 0);
    drain();
    do_frame();
    push_all("serve_auto");
    drain();
`else
    repeat (SF) do_frame();
    push_all("serve_wait");
    drain();
    do_start();
    push_all("serve_start");
    drain();
`endif

    // Build up to 8:8, then a simultaneous point ends in a draw
    for (int i = 0; i < 7; i++) begin
      do_point($sformatf("both%0d", i), 1'b1, 1'b1, 3);
      do_start();
    end
    do_point("p2_to8", 1'b0, 1'b1, 3);
    do_start();
    push_all("at8_8");
    drain();
    do_point("draw", 1'b1, 1'b1, 3);

    bus.btn_up2 = 1'b1;
    do_frame();
    bus.btn_up2 = 1'b0;
    push_all("over_frame");
    drain();

    do_start();
    push_all("over_restart");
    drain();
    do_start();
    push_all("replay");
    drain();

    // Reset in the middle of a serve delay
    do_point("pt_pre_rst", 1'b1, 1'b0, 3);
    bus.btn_up2 = 1'b1;
    repeat (10) do_frame();
    push_all("serve_mid");
    drain();
    i_rst = 1'b1;
    cyc(1);
    m_reset();
    push_all("mid_rst");
    drain();
    i_rst = 1'b0;
    bus.btn_up2 = 1'b0;
    do_frame();
    push_all("post_rst");
    drain();
    do_start();
    push_all("post_rst_start");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
